// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte strobes are queued in a small FIFO and shifted out LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 104,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_data_rdy,
    input  logic [7:0] tx_data,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int BW    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            sh_q, sh_d;
    logic                  txd_q, txd_d;
    logic                  ovf_q, ovf_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            mem_q [DEPTH];
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic       full, empty, wr_en, pop, baud_last;
    logic [7:0] head;

    // Full/empty come from the registered count, so a write on a full cycle is dropped even if a pop frees a slot.
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign wr_en     = tx_data_rdy && !full;
    assign head      = mem_q[rptr_q];
    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != S_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    bit_d   = '0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            S_START: begin
                if (baud_last) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        sh_d  = sh_q >> 1;
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = head;
                        bit_d   = '0;
                        state_d = S_START;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level is decoded from the next state and registered, so uart_txd never glitches.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        wptr_d = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        ovf_d  = ovf_q | (tx_data_rdy & full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
            if (wr_en) begin
                mem_q[wptr_q] <= tx_data;
            end
        end
    end

    assign uart_txd = txd_q;
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_full  = full;
    assign tx_empty = empty;
    assign tx_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=4, DEPTH_LOG2=3; follows UART_TX_PARITY_EN when defined.
module tb_uart_tx_fifo;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = B * NB;

    logic       clk;
    logic       rst;
    logic       tx_data_rdy;
    logic [7:0] tx_data;
    logic       uart_txd, tx_busy, tx_full, tx_empty, tx_ovf;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(.BAUD_DIV(B), .DEPTH_LOG2(3)) dut (
        .clk(clk), .rst(rst), .tx_data_rdy(tx_data_rdy), .tx_data(tx_data),
        .uart_txd(uart_txd), .tx_busy(tx_busy), .tx_full(tx_full),
        .tx_empty(tx_empty), .tx_ovf(tx_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tx_data     = b;
        tx_data_rdy = 1'b1;
        @(posedge clk);
        #1;
        tx_data_rdy = 1'b0;
    endtask

    // Samples one frame on successive negedges; bit value taken on its first clock, later clocks must match.
    task automatic capture(input bit immediate, output logic [7:0] d, output logic p,
                           output logic stp, output bit ok_start, output bit glitch,
                           output bit busy_ok, output logic empty0);
        logic [10:0] bits;
        int n;
        bits = '1; ok_start = 1'b1; glitch = 1'b0; busy_ok = 1'b1; n = 0;
        @(negedge clk);
        if (!immediate) begin
            while (uart_txd !== 1'b0 && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        if (uart_txd !== 1'b0) ok_start = 1'b0;
        bits[0] = uart_txd;
        empty0  = tx_empty;
        if (tx_busy !== 1'b1) busy_ok = 1'b0;
        for (int c = 1; c < FL; c++) begin
            @(negedge clk);
            if (c % B == 0) bits[c / B] = uart_txd;
            else if (uart_txd !== bits[c / B]) glitch = 1'b1;
            if (tx_busy !== 1'b1) busy_ok = 1'b0;
        end
        d   = bits[8:1];
        p   = (NB == 11) ? bits[9] : 1'b0;
        stp = bits[NB - 1];
    endtask

    task automatic do_frame(input bit immediate, input logic [7:0] exp_d, input logic exp_p,
                            output logic empty0);
        logic [7:0] d;
        logic p, stp;
        bit ok_start, glitch, busy_ok;
        capture(immediate, d, p, stp, ok_start, glitch, busy_ok, empty0);
        check("frame_start", {31'd0, ok_start}, 32'd1);
        check("frame_data", {24'd0, d}, {24'd0, exp_d});
        check("frame_stop", {31'd0, stp}, 32'd1);
        check("frame_stable", {31'd0, glitch}, 32'd0);
        check("frame_busy", {31'd0, busy_ok}, 32'd1);
`ifdef UART_TX_PARITY_EN
        check("frame_parity", {31'd0, p}, {31'd0, exp_p});
`else
        if (p !== 1'b0 || exp_p === 1'bx) check("frame_parity_absent", {31'd0, p}, 32'd0);
`endif
    endtask

    vec_t vecs[7];
    logic [8:0] burst_par;

    initial begin
        logic e0;
        int busy_cnt;
        bit idle_ok;

        vecs[0] = '{8'h41, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h55, 1'b0};
        // parity of 0x30..0x38, bit k for 0x30+k
        burst_par = 9'b1_1001_0110;

        rst = 1'b0; tx_data_rdy = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_full", {31'd0, tx_full}, 32'd0);
        check("rst_empty", {31'd0, tx_empty}, 32'd1);
        check("rst_ovf", {31'd0, tx_ovf}, 32'd0);
        rst = 1'b1;

        // Single-frame vectors
        for (int v = 0; v < 7; v++) begin
            sync();
            send(vecs[v].data);
            @(negedge clk);
            check("pre_pop_txd", {31'd0, uart_txd}, 32'd1);
            check("pre_pop_empty", {31'd0, tx_empty}, 32'd0);
            check("pre_pop_busy", {31'd0, tx_busy}, 32'd0);
            do_frame(1'b1, vecs[v].data, vecs[v].par, e0);
            check("empty_after_pop", {31'd0, e0}, 32'd1);
            @(negedge clk);
            check("post_busy", {31'd0, tx_busy}, 32'd0);
            check("post_txd", {31'd0, uart_txd}, 32'd1);
        end

        // Back-to-back: 0x55 then 0xAA three clocks later
        sync();
        busy_cnt = 0;
        fork
            begin
                send(8'h55);
                repeat (2) @(posedge clk);
                #1;
                send(8'hAA);
            end
            begin
                do_frame(1'b0, 8'h55, 1'b0, e0);
                do_frame(1'b1, 8'hAA, 1'b0, e0);
            end
            begin
                for (int i = 0; i < 2 * FL + 20; i++) begin
                    @(negedge clk);
                    if (tx_busy === 1'b1) busy_cnt++;
                end
            end
        join
        check("b2b_busy_clocks", busy_cnt, 2 * FL);

        // Burst of ten strobes into an 8-deep FIFO
        sync();
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    tx_data     = 8'h30 + 8'(k);
                    tx_data_rdy = 1'b1;
                    @(posedge clk);
                    #1;
                    if (k == 8) begin
                        check("burst_full_k8", {31'd0, tx_full}, 32'd1);
                        check("burst_ovf_k8", {31'd0, tx_ovf}, 32'd0);
                    end
                end
                tx_data_rdy = 1'b0;
                check("burst_full_end", {31'd0, tx_full}, 32'd1);
                check("burst_ovf_end", {31'd0, tx_ovf}, 32'd1);
            end
            begin
                for (int k = 0; k < 9; k++) begin
                    do_frame(k > 0, 8'h30 + 8'(k), burst_par[k], e0);
                end
            end
        join
        @(negedge clk);
        check("drain_busy", {31'd0, tx_busy}, 32'd0);
        check("drain_empty", {31'd0, tx_empty}, 32'd1);
        check("drain_ovf", {31'd0, tx_ovf}, 32'd1);
        idle_ok = 1'b1;
        for (int i = 0; i < 3 * FL; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
        end
        check("no_dropped_frame", {31'd0, idle_ok}, 32'd1);
        check("ovf_sticky", {31'd0, tx_ovf}, 32'd1);

        // Asynchronous reset during data bit 3 of 0x0F, with 0x33 still buffered
        sync();
        send(8'h0F);
        send(8'h33);
        repeat (4 * B) @(posedge clk);
        #2;
        check("midframe_busy", {31'd0, tx_busy}, 32'd1);
        check("midframe_empty", {31'd0, tx_empty}, 32'd0);
        rst = 1'b0;
        #1;
        check("async_txd", {31'd0, uart_txd}, 32'd1);
        check("async_busy", {31'd0, tx_busy}, 32'd0);
        check("async_full", {31'd0, tx_full}, 32'd0);
        check("async_empty", {31'd0, tx_empty}, 32'd1);
        check("async_ovf", {31'd0, tx_ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 3 * FL; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) idle_ok = 1'b0;
        end
        check("idle_after_reset", {31'd0, idle_ok}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-serializing UART transmitter with an input FIFO. It is the transmit-side counterpart of the UART receive path that feeds `bu_rx_data`/`bu_rx_data_rdy` into the lab modules. It accepts the one-cycle `*_tx_data_rdy`/`*_tx_data` byte strobes that the display and alarm blocks produce (e.g. `L3_tx_data`), buffers them, and shifts them out as 8N1 serial frames on the board TX pin. Those producers never wait, so the FIFO absorbs bursts such as a full display string.

## Interface
Parameters:
- `BAUD_DIV`, 104: clocks per serial bit (12 MHz / 115200); legal ≥ 2.
- `DEPTH_LOG2`, 3: FIFO depth = 2^DEPTH_LOG2 entries (default 8).

Ports:
- `clk`  in  1  global clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low: asserting low clears all state immediately; release is sampled on `clk`.
- `tx_data_rdy`  in  1  one-cycle strobe, byte valid.
- `tx_data`  in  8  byte to send, sampled when `tx_data_rdy`=1.
- `uart_txd`  out  1  serial line, idle high.
- `tx_busy`  out  1  high while a frame is on the line (start through stop).
- `tx_full`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `tx_empty`  out  1  FIFO holds 0 entries.
- `tx_ovf`  out  1  sticky: a strobe arrived while full; cleared only by reset.

## Operation
- FIFO: circular buffer with DEPTH_LOG2-bit read/write pointers and a (DEPTH_LOG2+1)-bit count.
  - Write on `tx_data_rdy` && !`tx_full`.
  - Strobe while full: byte discarded, `tx_ovf` set, FIFO unchanged.
  - Full is judged on the registered count. A write arriving on the same cycle as a pop while full is still dropped.
  - A simultaneous write and pop when not full leaves the count unchanged.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: `uart_txd`=1. If !`tx_empty`, pop the head into shift register `sh`, clear the bit counter, and go to START.
  - START: `uart_txd`=0 for BAUD_DIV clocks, then go to DATA.
  - DATA: `uart_txd`=`sh[0]`, LSB first. Shift right every BAUD_DIV clocks. After 8 bits, go to PARITY if compiled in, otherwise go to STOP.
  - PARITY: `uart_txd` = XOR of the 8 data bits (even parity), for BAUD_DIV clocks.
  - STOP: `uart_txd`=1 for BAUD_DIV clocks. At the end, if !`tx_empty`, pop and go straight to START with no idle gap; else go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 and resets to 0 on every state change. It is held at 0 in IDLE.
- `tx_busy` = (state != IDLE).
- `uart_txd` is driven from a register (glitch-free), not decoded combinationally.

## Timing
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_full`=0, `tx_empty`=1, `tx_ovf`=0, FIFO count 0, pointers 0, FSM in IDLE.
- Latency from an idle, empty block: strobe sampled at edge N → FIFO non-empty after N → pop at edge N+1 → `uart_txd` falls after edge N+1.
- Frame length: 10·BAUD_DIV clocks, or 11·BAUD_DIV with parity.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- `tx_full`/`tx_empty` update the cycle after the write or pop edge.
- The FIFO accepts one byte per clock; the producer has no backpressure.
- Reset mid-frame: the line goes high asynchronously and the frame is truncated. Buffered bytes are lost, and the block restarts in IDLE after reset release.
- The pop happens at the IDLE→START or STOP→START transition, so the head entry leaves the FIFO while the start bit is sent.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and frames are 8E1 (11 bits).
- Not defined: the PARITY state and XOR logic are absent and frames are 8N1 (10 bits).
- FIFO behaviour, flags and reset behaviour are identical in both builds.

## Test plan
- Single byte, BAUD_DIV=4, no parity: strobe 0x41.
  - Expect `uart_txd` low starting 1 clock after the strobe edge.
  - Then bits 1,0,0,0,0,0,1,0, each 4 clocks, then high 4 clocks.
  - `tx_busy` high for exactly 40 clocks; `tx_empty` back to 1 one cycle after the pop.
- Burst overflow, DEPTH_LOG2=3, BAUD_DIV=4: 10 strobes on consecutive clocks, 0x30..0x39.
  - The first byte is popped at the next edge.
  - Entries 2–9 fill the FIFO; `tx_full`=1; the 10th byte (0x39) is dropped and `tx_ovf`=1.
  - The line emits 0x30..0x38 in order with no idle gaps between frames.
- Back-to-back: strobe 0x55, then strobe 0xAA 3 clocks later.
  - Stop bit of 0x55 is followed immediately by the start bit of 0xAA.
  - Total busy time 80 clocks at BAUD_DIV=4.
- Reset mid-frame: assert `rst`=0 asynchronously during bit 3 of 0x0F.
  - `uart_txd`=1, all flags at reset values, before the next clock edge.
  - After release, with no new strobe, the line stays idle.
- Parity build (`UART_TX_PARITY_EN`), BAUD_DIV=4: send 0x07, then 0x03.
  - Parity bits are 1 and 0 respectively; each frame lasts 44 clocks.
- Ovf persistence: after an overflow, drain the FIFO completely.
  - `tx_ovf` stays 1 until `rst` is asserted.
